// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: operand forwarding, load-use and multiply/divide stalls, branch flush.
// Optional stall statistics counter enabled with macro HAZ_STATS_EN.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              use_rs_i,
  input  logic              use_rt_i,
  input  logic              ewreg_i,
  input  logic              em2reg_i,
  input  logic [REG_AW-1:0] ern_i,
  input  logic              mwreg_i,
  input  logic              mm2reg_i,
  input  logic [REG_AW-1:0] mrn_i,
  input  logic              md_start_i,
  input  logic              md_read_i,
  input  logic              br_taken_i,
  output logic [1:0]        fwda_o,
  output logic [1:0]        fwdb_o,
  output logic              wpcir_o,
  output logic              bubble_o,
  output logic              if_flush_o,
  output logic              md_busy_o,
  output logic [CNT_W-1:0]  md_count_o
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]       stall_cycles_o
`endif
);

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_EX   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_LOAD = 2'b11
  } fwd_sel_e;

  logic [CNT_W-1:0] md_count_q, md_count_d;
  logic             ex_wr_nz, mem_wr_nz;
  logic             load_use, md_stall, stall;
  fwd_sel_e         fwda_sel, fwdb_sel;

  // Register 0 is hard-wired to zero, so a write to it is never a real producer.
  assign ex_wr_nz  = ewreg_i & (ern_i != '0);
  assign mem_wr_nz = mwreg_i & (mrn_i != '0);

  function automatic fwd_sel_e fwd_decode(input logic [REG_AW-1:0] src);
    if (ex_wr_nz && !em2reg_i && (ern_i == src)) begin
      return FWD_EX;
    end else if (mem_wr_nz && !mm2reg_i && (mrn_i == src)) begin
      return FWD_MEM;
    end else if (mem_wr_nz && mm2reg_i && (mrn_i == src)) begin
      return FWD_LOAD;
    end
    return FWD_RF;
  endfunction

  always_comb begin
    fwda_sel = fwd_decode(rs_i);
    fwdb_sel = fwd_decode(rt_i);
  end

  assign fwda_o = fwda_sel;
  assign fwdb_o = fwdb_sel;

  // A load in EX cannot feed the ID instruction until it reaches MEM.
  assign load_use = ex_wr_nz & em2reg_i &
                    (((ern_i == rs_i) & use_rs_i) | ((ern_i == rt_i) & use_rt_i));
  assign md_busy_o = (md_count_q != '0);
  assign md_stall  = md_busy_o & (md_start_i | md_read_i);
  assign stall     = load_use | md_stall;

  assign wpcir_o    = ~stall;
  assign bubble_o   = stall;
  assign if_flush_o = br_taken_i & ~stall;
  assign md_count_o = md_count_q;

  always_comb begin
    // NOTE: default first so every path assigns md_count_d and no latch is inferred.
    md_count_d = md_count_q;
    if (md_start_i && !stall) begin
      md_count_d = CNT_W'(MD_LAT);
    end else if (md_count_q != '0) begin
      md_count_d = md_count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst_i) begin
      md_count_q <= '0;
    end else begin
      md_count_q <= md_count_d;
    end
  end

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: behavioural model feeds an expected-result queue,
// compared on the falling edge; directed cases for forwarding, load-use, MD and reset.
module tb_pipe_hazard_ctrl;
  localparam int REG_AW = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] rs, rt, ern, mrn;
  logic              use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg;
  logic              md_start, md_read, br_taken;
  logic [1:0]        fwda, fwdb;
  logic              wpcir, bubble, if_flush, md_busy;
  logic [CNT_W-1:0]  md_count;
`ifdef HAZ_STATS_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       m_stats;
`endif

  typedef struct packed {
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic             wpcir;
    logic             bubble;
    logic             if_flush;
    logic             md_busy;
    logic [CNT_W-1:0] md_count;
  } exp_t;

  exp_t exp_q[$];
  int   m_cnt;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .rs_i(rs), .rt_i(rt), .use_rs_i(use_rs), .use_rt_i(use_rt),
    .ewreg_i(ewreg), .em2reg_i(em2reg), .ern_i(ern),
    .mwreg_i(mwreg), .mm2reg_i(mm2reg), .mrn_i(mrn),
    .md_start_i(md_start), .md_read_i(md_read), .br_taken_i(br_taken),
    .fwda_o(fwda), .fwdb_o(fwdb), .wpcir_o(wpcir), .bubble_o(bubble),
    .if_flush_o(if_flush), .md_busy_o(md_busy), .md_count_o(md_count)
`ifdef HAZ_STATS_EN
    , .stall_cycles_o(stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [REG_AW-1:0] src);
    if (ewreg && !em2reg && ern != 0 && ern == src) return 2'b01;
    if (mwreg && !mm2reg && mrn != 0 && mrn == src) return 2'b10;
    if (mwreg && mm2reg && mrn != 0 && mrn == src) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic m_stall();
    logic lu, ms;
    lu = ewreg && em2reg && ern != 0 &&
         ((ern == rs && use_rs) || (ern == rt && use_rt));
    ms = (m_cnt != 0) && (md_start || md_read);
    return lu || ms;
  endfunction

  task automatic clear_inputs();
    {rs, rt, ern, mrn} = '0;
    {use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg} = '0;
    {md_start, md_read, br_taken} = '0;
  endtask

  // One pipeline cycle: predict, compare at negedge, advance the model at posedge.
  task automatic cycle();
    exp_t e, g;
    logic st;
    st         = m_stall();
    e.fwda     = m_fwd(rs);
    e.fwdb     = m_fwd(rt);
    e.wpcir    = ~st;
    e.bubble   = st;
    e.if_flush = br_taken & ~st;
    e.md_busy  = (m_cnt != 0);
    e.md_count = CNT_W'(m_cnt);
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    g = '{fwda, fwdb, wpcir, bubble, if_flush, md_busy, md_count};
    check("fwda", 32'(g.fwda), 32'(e.fwda));
    check("fwdb", 32'(g.fwdb), 32'(e.fwdb));
    check("wpcir", 32'(g.wpcir), 32'(e.wpcir));
    check("bubble", 32'(g.bubble), 32'(e.bubble));
    check("if_flush", 32'(g.if_flush), 32'(e.if_flush));
    check("md_busy", 32'(g.md_busy), 32'(e.md_busy));
    check("md_count", 32'(g.md_count), 32'(e.md_count));
`ifdef HAZ_STATS_EN
    check("stall_cycles", stall_cycles, m_stats);
`endif
    @(posedge clk);
    if (md_start && !st) m_cnt = MD_LAT;
    else if (m_cnt != 0) m_cnt--;
`ifdef HAZ_STATS_EN
    if (st && m_stats != 32'hFFFF_FFFF) m_stats++;
`endif
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int accept;
    clear_inputs();
    m_cnt = 0;
`ifdef HAZ_STATS_EN
    m_stats = 0;
`endif
    rst = 1'b1;
    #12;
    check("rst_md_count", 32'(md_count), 0);
    check("rst_md_busy", 32'(md_busy), 0);
    check("rst_wpcir", 32'(wpcir), 1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    // Forwarding priority and register-0 exclusion
    ern = 3; ewreg = 1; em2reg = 0; mrn = 3; mwreg = 1; rs = 3; #1;
    check("fwda_ex", 32'(fwda), 1);
    cycle();
    ewreg = 0; #1;
    check("fwda_mem", 32'(fwda), 2);
    cycle();
    mm2reg = 1; #1;
    check("fwda_load", 32'(fwda), 3);
    cycle();
    ewreg = 1; mm2reg = 0; rs = 0; ern = 0; mrn = 0; #1;
    check("fwda_r0", 32'(fwda), 0);
    cycle();

    // Load-use with a branch behind it
    clear_inputs();
    ewreg = 1; em2reg = 1; ern = 5; rt = 5; use_rt = 1; br_taken = 1; #1;
    check("lu_wpcir", 32'(wpcir), 0);
    check("lu_bubble", 32'(bubble), 1);
    check("lu_flush", 32'(if_flush), 0);
    cycle();
    ewreg = 0; em2reg = 0; ern = 0; mwreg = 1; mm2reg = 1; mrn = 5; #1;
    check("lu_fwdb", 32'(fwdb), 3);
    check("lu_release", 32'(wpcir), 1);
    check("lu_flush_rel", 32'(if_flush), 1);
    cycle();

    // Multiply/divide countdown with a HI/LO read behind it
    clear_inputs();
    md_start = 1; #1;
    check("md_c0", 32'(md_count), 0);
    cycle();
    md_start = 0; md_read = 1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check("md_cnt", 32'(md_count), 32'(5 - k));
      check("md_rd_wpcir", 32'(wpcir), (k == 5) ? 1 : 0);
      cycle();
    end

    // Back-to-back issue latency
    clear_inputs();
    md_start = 1; accept = -1;
    for (int k = 0; k <= 6; k++) begin
      #1;
      if (k > 0 && wpcir && accept < 0) accept = k;
      cycle();
    end
    check("md_b2b", 32'(accept), MD_LAT + 1);
    md_start = 0;
    repeat (6) cycle();

    // Reset mid-countdown
    md_start = 1; cycle();
    md_start = 0; cycle(); cycle();
    #1 check("md_pre_rst", 32'(md_count), 2);
    rst = 1'b1; md_read = 1; #1;
    check("rst_async_cnt", 32'(md_count), 0);
    check("rst_md_wpcir", 32'(wpcir), 1);
    m_cnt = 0;
`ifdef HAZ_STATS_EN
    m_stats = 0;
    check("rst_stats", stall_cycles, 0);
`endif
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    cycle();

`ifdef HAZ_STATS_EN
    clear_inputs();
    dut.stall_cycles_q = 32'hFFFF_FFFD;
    m_stats = 32'hFFFF_FFFD;
    #1;
    ewreg = 1; em2reg = 1; ern = 7; rs = 7; use_rs = 1;
    repeat (3) cycle();
    check("stats_sat", stall_cycles, 32'hFFFF_FFFF);
`endif

    // Randomised traffic over a small register set to provoke matches
    for (int i = 0; i < 300; i++) begin
      rs = REG_AW'($urandom_range(0, 3));
      rt = REG_AW'($urandom_range(0, 3));
      ern = REG_AW'($urandom_range(0, 3));
      mrn = REG_AW'($urandom_range(0, 3));
      {use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg, br_taken} = 7'($urandom);
      md_start = ($urandom_range(0, 7) == 0);
      md_read  = ($urandom_range(0, 5) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
